uart_cmd_parser: RTL and testbench
==================================

// Module: uart_cmd_parser
// PURPOSE
//  Frame sequencer downstream of the UART receiver. Consumes the receiver's byte
//  strobe (DV + byte), finds a 2-byte header, collects CMD + 4 data bytes, and
//  checks an XOR checksum. Emits one registered command word per good frame;
//  flags bad-checksum and inter-byte-timeout errors. Feeds the register/config layer.
// PARAMETERS
//  HDR0          8'hAB   first header byte
//  HDR1          8'hBA   second header byte
//  TIMEOUT_CLKS  43400   max clocks between bytes inside a frame (~10 byte times @434)
// PORTS
//  i_Clock        in   1   system clock, all logic on rising edge
//  i_Rst_n        in   1   asynchronous active-low reset
//  i_Rx_DV        in   1   1-cycle strobe: i_Rx_Byte valid (from UART RX)
//  i_Rx_Byte      in   8   received byte
//  o_Cmd_Valid    out  1   1-cycle pulse: o_Cmd/o_Data hold a new good frame
//  o_Cmd          out  8   command byte of last good frame
//  o_Data         out  32  payload of last good frame, first data byte = [31:24]
//  o_Err          out  1   1-cycle pulse on frame error
//  o_Err_Code     out  2   01=bad checksum, 10=timeout; held until next o_Err
//  o_Frame_Cnt    out  16  good-frame count, wraps FFFF->0000
//  o_Busy         out  1   1 when state != S_IDLE
// BEHAVIOUR
//  Interface: one clock i_Clock; reset is asynchronous, active-low (i_Rst_n).
//  Reset: state=S_IDLE; all outputs, data/cmd regs, checksum, counters = 0.
//   Reset asserted mid-frame discards the partial frame; no o_Err is generated.
//  Frame: HDR0 HDR1 CMD D0 D1 D2 D3 CHK; CHK = CMD^D0^D1^D2^D3.
//  No backpressure: every i_Rx_DV is consumed in its cycle; action only on DV.
//  FSM (advances only on i_Rx_DV, except timeout):
//   S_IDLE: byte==HDR0 -> S_HDR1; else stay.
//   S_HDR1: byte==HDR1 -> S_CMD; byte==HDR0 -> stay (resync); else -> S_IDLE.
//    No o_Err for header mismatch.
//   S_CMD:  latch cmd, chk<=byte -> S_DATA, byte index=0.
//   S_DATA: shift byte into data shadow, chk^=byte; after 4th byte -> S_CHK.
//   S_CHK:  byte==chk -> o_Cmd/o_Data <= shadows, o_Cmd_Valid=1,
//            o_Frame_Cnt+=1; else o_Err=1, o_Err_Code=01. Both -> S_IDLE.
//  Latency: o_Cmd_Valid/o_Err asserted the cycle after the CHK-byte DV cycle
//   (registered outputs); both are single-cycle pulses, never both high.
//  o_Cmd/o_Data change only on a good frame; a bad frame leaves the prior value.
//  Timeout: gap counter cleared on every DV and in S_IDLE; increments otherwise.
//   When gap == TIMEOUT_CLKS-1 and state != S_IDLE and no DV that cycle:
//   o_Err=1, o_Err_Code=10, -> S_IDLE. DV in the same cycle wins, no timeout.
//   Counter width = $clog2(TIMEOUT_CLKS+1); saturating, no wrap.
//  Back-to-back: a DV the cycle after S_CHK is evaluated in S_IDLE (HDR0 accepted).
// TESTING
//  1 Frame AB BA 12 01 02 03 04 CHK=0x16 -> one o_Cmd_Valid, o_Cmd=12,
//    o_Data=01020304, o_Frame_Cnt=1, o_Err never high.
//  2 Same frame with CHK=0x17 -> o_Err=1, o_Err_Code=01, o_Data unchanged, cnt unchanged.
//  3 AB AB BA 05 00 00 00 00 05 -> resync; good frame, o_Cmd=05, o_Data=0.
//  4 AB BA 12, then no DV for TIMEOUT_CLKS clocks -> o_Err, code 10, o_Busy=0;
//    a following good frame is accepted.
//  5 i_Rst_n low after D1 of a frame -> all outputs 0 immediately, no o_Err;
//    after release, a full good frame is accepted.
//  6 65536 good frames (or forced cnt=FFFF) -> o_Frame_Cnt wraps to 0000.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// Frame sequencer behind the UART receiver: finds the AB BA header, collects CMD plus four data bytes,
// checks the XOR checksum and reports good frames, bad-checksum errors and inter-byte timeouts.
module uart_cmd_parser #(
    parameter logic [7:0]  HDR0         = 8'hAB,
    parameter logic [7:0]  HDR1         = 8'hBA,
    parameter int unsigned TIMEOUT_CLKS = 43400
) (
    input  logic        i_Clock,
    input  logic        i_Rst_n,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    output logic        o_Cmd_Valid,
    output logic [7:0]  o_Cmd,
    output logic [31:0] o_Data,
    output logic        o_Err,
    output logic [1:0]  o_Err_Code,
    output logic [15:0] o_Frame_Cnt,
    output logic        o_Busy
);

    localparam int unsigned GAP_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CLKS - 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = {GAP_W{1'b1}};

    localparam logic [1:0] ERR_CHK     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR1,
        S_CMD,
        S_DATA,
        S_CHK
    } state_t;

    state_t      r_state;
    logic [GAP_W-1:0] r_gap;
    logic [1:0]  r_idx;
    logic [7:0]  r_chk;
    logic [7:0]  r_cmd_sh;
    logic [31:0] r_data_sh;
    logic        r_cmd_valid;
    logic [7:0]  r_cmd;
    logic [31:0] r_data;
    logic        r_err;
    logic [1:0]  r_err_code;
    logic [15:0] r_frame_cnt;

    logic        w_timeout;

    // A byte arriving on the last allowed gap cycle takes priority over the timeout.
    assign w_timeout = (r_state != S_IDLE) && !i_Rx_DV && (r_gap == GAP_LAST);

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state     <= S_IDLE;
            r_gap       <= '0;
            r_idx       <= '0;
            r_chk       <= '0;
            r_cmd_sh    <= '0;
            r_data_sh   <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd       <= '0;
            r_data      <= '0;
            r_err       <= 1'b0;
            r_err_code  <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_err       <= 1'b0;

            if (i_Rx_DV || (r_state == S_IDLE)) begin
                r_gap <= '0;
            end else if (r_gap != GAP_MAX) begin
                r_gap <= r_gap + GAP_W'(1);
            end

            if (w_timeout) begin
                r_state    <= S_IDLE;
                r_err      <= 1'b1;
                r_err_code <= ERR_TIMEOUT;
            end else if (i_Rx_DV) begin
                case (r_state)
                    S_IDLE: begin
                        if (i_Rx_Byte == HDR0) begin
                            r_state <= S_HDR1;
                        end
                    end
                    S_HDR1: begin
                        if (i_Rx_Byte == HDR1) begin
                            r_state <= S_CMD;
                        end else if (i_Rx_Byte != HDR0) begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_CMD: begin
                        r_cmd_sh <= i_Rx_Byte;
                        r_chk    <= i_Rx_Byte;
                        r_idx    <= '0;
                        r_state  <= S_DATA;
                    end
                    S_DATA: begin
                        r_data_sh <= {r_data_sh[23:0], i_Rx_Byte};
                        r_chk     <= r_chk ^ i_Rx_Byte;
                        r_idx     <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_state <= S_CHK;
                        end
                    end
                    S_CHK: begin
                        if (i_Rx_Byte == r_chk) begin
                            r_cmd       <= r_cmd_sh;
                            r_data      <= r_data_sh;
                            r_cmd_valid <= 1'b1;
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                        end else begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_CHK;
                        end
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_Cmd_Valid = r_cmd_valid;
    assign o_Cmd       = r_cmd;
    assign o_Data      = r_data;
    assign o_Err       = r_err;
    assign o_Err_Code  = r_err_code;
    assign o_Frame_Cnt = r_frame_cnt;
    assign o_Busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: a byte-queue frame model checked against the DUT every cycle,
// plus literal expectations after each scenario.
module tb_uart_cmd_parser;

    localparam int unsigned T = 100;
    localparam logic [7:0] H0 = 8'hAB;
    localparam logic [7:0] H1 = 8'hBA;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        cmd_valid;
    logic [7:0]  cmd;
    logic [31:0] data;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] frame_cnt;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int valid_seen = 0;
    int err_seen = 0;
    logic force_req = 1'b0;

    // Expected outputs from the model
    logic        m_valid;
    logic [7:0]  m_cmd;
    logic [31:0] m_data;
    logic        m_err;
    logic [1:0]  m_code;
    logic [15:0] m_cnt;
    logic        m_busy;

    uart_cmd_parser #(.HDR0(H0), .HDR1(H1), .TIMEOUT_CLKS(T)) dut (
        .i_Clock     (clk),
        .i_Rst_n     (rst_n),
        .i_Rx_DV     (rx_dv),
        .i_Rx_Byte   (rx_byte),
        .o_Cmd_Valid (cmd_valid),
        .o_Cmd       (cmd),
        .o_Data      (data),
        .o_Err       (err),
        .o_Err_Code  (err_code),
        .o_Frame_Cnt (frame_cnt),
        .o_Busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Frame model: the queue holds the bytes of the frame candidate currently being assembled.
    initial begin : model
        logic [7:0] q[$];
        int unsigned idle;
        logic [7:0] x;
        idle = 0;
        m_valid = 0; m_cmd = 0; m_data = 0; m_err = 0; m_code = 0; m_cnt = 0; m_busy = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                idle = 0;
                m_valid = 0; m_cmd = 0; m_data = 0; m_err = 0; m_code = 0; m_cnt = 0; m_busy = 0;
            end else begin
                m_valid = 0;
                m_err   = 0;
                if (force_req) m_cnt = 16'hFFFF;
                if (rx_dv) begin
                    idle = 0;
                    case (q.size())
                        0: if (rx_byte == H0) q.push_back(rx_byte);
                        1: begin
                            if (rx_byte == H1) q.push_back(rx_byte);
                            else if (rx_byte != H0) q.delete();
                        end
                        7: begin
                            x = q[2] ^ q[3] ^ q[4] ^ q[5] ^ q[6];
                            if (rx_byte == x) begin
                                m_cmd   = q[2];
                                m_data  = {q[3], q[4], q[5], q[6]};
                                m_valid = 1;
                                m_cnt   = m_cnt + 16'd1;
                            end else begin
                                m_err  = 1;
                                m_code = 2'b01;
                            end
                            q.delete();
                        end
                        default: q.push_back(rx_byte);
                    endcase
                end else begin
                    if (idle < 32'd1000000) idle++;
                    if (q.size() != 0 && idle == T) begin
                        q.delete();
                        m_err  = 1;
                        m_code = 2'b10;
                    end
                end
                m_busy = (q.size() != 0);
            end
        end
    end

    // Per-cycle comparison, away from the active edge
    initial begin : compare
        forever begin
            @(negedge clk);
            if (cmd_valid === 1'b1) valid_seen++;
            if (err === 1'b1) err_seen++;
            chk("cmd_valid", 32'(cmd_valid), 32'(m_valid));
            chk("cmd", 32'(cmd), 32'(m_cmd));
            chk("data", data, m_data);
            chk("err", 32'(err), 32'(m_err));
            chk("err_code", 32'(err_code), 32'(m_code));
            chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("valid_and_err", 32'(cmd_valid & err), 32'd0);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [31:0] d, input logic [7:0] ck);
        send_byte(H0);
        send_byte(H1);
        send_byte(c);
        for (int i = 3; i >= 0; i--) begin
            send_byte(d[i*8 +: 8]);
        end
        send_byte(ck);
    endtask

    initial begin : stimulus
        rst_n   = 1'b0;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Good frame
        send_frame(8'h12, 32'h01020304, 8'h16);
        repeat (3) @(negedge clk);
        chk("t1_cmd", 32'(cmd), 32'h12);
        chk("t1_data", data, 32'h01020304);
        chk("t1_cnt", 32'(frame_cnt), 32'd1);
        chk("t1_err_seen", 32'(err_seen), 32'd0);
        chk("t1_valid_seen", 32'(valid_seen), 32'd1);

        // Bad checksum
        send_frame(8'h12, 32'h01020304, 8'h17);
        repeat (3) @(negedge clk);
        chk("t2_code", 32'(err_code), 32'h1);
        chk("t2_data", data, 32'h01020304);
        chk("t2_cnt", 32'(frame_cnt), 32'd1);
        chk("t2_err_seen", 32'(err_seen), 32'd1);

        // Header resync on repeated HDR0
        send_byte(8'hAB);
        send_frame(8'h05, 32'h00000000, 8'h05);
        repeat (3) @(negedge clk);
        chk("t3_cmd", 32'(cmd), 32'h05);
        chk("t3_data", data, 32'h0);
        chk("t3_cnt", 32'(frame_cnt), 32'd2);

        // Inter-byte timeout after CMD
        send_byte(H0);
        send_byte(H1);
        send_byte(8'h12);
        repeat (T + 5) @(negedge clk);
        chk("t4_code", 32'(err_code), 32'h2);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_err_seen", 32'(err_seen), 32'd2);
        send_frame(8'h33, 32'h10203040, 8'h73);
        repeat (3) @(negedge clk);
        chk("t4_cmd", 32'(cmd), 32'h33);
        chk("t4_cnt", 32'(frame_cnt), 32'd3);

        // Byte lands on the last allowed gap cycle: no timeout
        send_byte(H0);
        send_byte(H1);
        send_byte(8'h12);
        repeat (T - 2) @(negedge clk);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h16);
        repeat (3) @(negedge clk);
        chk("edge_err_seen", 32'(err_seen), 32'd2);
        chk("edge_cnt", 32'(frame_cnt), 32'd4);

        // Reset mid-frame after D1
        send_byte(H0);
        send_byte(H1);
        send_byte(8'h12);
        send_byte(8'h01);
        send_byte(8'h02);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_cnt", 32'(frame_cnt), 32'd0);
        chk("t5_cmd", 32'(cmd), 32'd0);
        chk("t5_data", data, 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_err", 32'(err), 32'd0);
        chk("t5_code", 32'(err_code), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        send_frame(8'h12, 32'h01020304, 8'h16);
        repeat (3) @(negedge clk);
        chk("t5_cnt_after", 32'(frame_cnt), 32'd1);
        chk("t5_err_seen", 32'(err_seen), 32'd2);

        // Counter wrap from FFFF
        @(negedge clk);
        #2;
        force dut.r_frame_cnt = 16'hFFFF;
        force_req = 1'b1;
        @(negedge clk);
        #2;
        release dut.r_frame_cnt;
        force_req = 1'b0;
        send_frame(8'h5A, 32'hDEADBEEF, 8'h5A ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
        repeat (3) @(negedge clk);
        chk("t6_cnt", 32'(frame_cnt), 32'd0);
        chk("t6_data", data, 32'hDEADBEEF);
        chk("valid_total", 32'(valid_seen), 32'd6);
        chk("err_total", 32'(err_seen), 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
